serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/full_adder_cell.sv | 43 ++++
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder shared types and constants.
// State encoding, W limits and counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_MIN = 1;
  localparam int W_MAX = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder: two half adders and an OR.
// Combinational; used as the serial adder's bit cell.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .co(c0)
  );

  half_adder u_ha1 (
    .a (s0),
    .b (ci),
    .s (s),
    .co(c1)
  );

  assign co = c0 | c1;

endmodule

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);

  assign s  = a ^ b;
  assign co = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, LSB first, start/done handshake.
// Define SERIAL_ADDER_OVF_EN to add the signed overflow port ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t state;
  state_t state_n;

  logic [W-1:0]  sa;
  logic [W-1:0]  sb;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_n;
  logic          c;
  logic [CW-1:0] cnt;
  logic          s;
  logic          co;
  logic          last;

`ifdef SERIAL_ADDER_OVF_EN
  logic c_msb_in;
`endif

  full_adder_cell u_fa (
    .a (sa[0]),
    .b (sb[0]),
    .ci(c),
    .s (s),
    .co(co)
  );

  assign last  = (cnt == LAST);
  assign acc_n = (acc >> 1) | (W'(s) << (W - 1));
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; DONE always lasts one cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, bit-serial shift and result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa   <= '0;
      sb   <= '0;
      acc  <= '0;
      c    <= 1'b0;
      cnt  <= '0;
      sum  <= '0;
      cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      c_msb_in <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else if (state == IDLE && start) begin
      sa  <= a;
      sb  <= b;
      c   <= cin;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      acc <= acc_n;
      c   <= co;
      cnt <= cnt + CW'(1);
      if (last) begin
        sum  <= acc_n;
        cout <= co;
`ifdef SERIAL_ADDER_OVF_EN
        c_msb_in <= c;
        ovf      <= c ^ co;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (W=8 and W=1).
// Table vectors, random ops vs arithmetic model, corner sequences.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic start1 = 1'b0;
  logic a1 = 1'b0;
  logic b1 = 1'b0;
  logic cin1 = 1'b0;
  logic busy1;
  logic done1;
  logic sum1;
  logic cout1;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf;
  logic ovf1;
`endif

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  serial_adder #(.W(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  serial_adder #(.W(1)) dut1 (
    .clk  (clk),
    .rst  (rst),
    .start(start1),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .busy (busy1),
    .done (done1),
    .sum  (sum1),
    .cout (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf1)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic run_add(input logic [7:0] ta, input logic [7:0] tb,
                         input logic tc, input logic [7:0] es,
                         input logic eco, input string nm);
    int lat;
    int nbusy;
    int sv;
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
    lat = 1;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, lat, 9);
    check({nm, " busy cycles"}, nbusy, 8);
    check({nm, " busy in done"}, busy, 0);
    check({nm, " sum"}, sum, es);
    check({nm, " cout"}, cout, eco);
`ifdef SERIAL_ADDER_OVF_EN
    sv = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
    check({nm, " ovf"}, ovf, (sv > 127 || sv < -128) ? 1 : 0);
`else
    sv = 0;
`endif
    @(negedge clk);
    check({nm, " done width"}, done, 0);
    check({nm, " sum held"}, sum, es);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [8:0] r9;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int lat;
    int t;
    int prev;
    bit seen;

    vt[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vt[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vt[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[6] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};

    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset busy1", busy1, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_add(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co,
              $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(0, 1));
      r9 = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      run_add(ra, rb, rc, r9[7:0], r9[8], $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    a = 8'h05;
    b = 8'h03;
    cin = 1'b0;
    start = 1'b1;
    t = 0;
    prev = 0;
    for (int r = 0; r < 3; r++) begin
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
        t++;
        if (lat == 4) begin
          a = 8'hFF;
          b = 8'hFF;
        end
      end while (!done && lat < 40);
      check($sformatf("held start sum%0d", r), sum, 8'h08);
      if (r > 0) begin
        check($sformatf("held start period%0d", r), t - prev, 10);
      end
      prev = t;
      a = 8'h05;
      b = 8'h03;
    end
    start = 1'b0;
    repeat (2) @(negedge clk);

    run_add(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "pre-abort");
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort running", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort no done", seen, 0);

    rst = 1'b1;
    start = 1'b1;
    a = 8'h01;
    b = 8'h01;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("start during rst", busy, 0);
    run_add(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, "post-abort");

    @(negedge clk);
    a1 = 1'b1;
    b1 = 1'b1;
    cin1 = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    a1 = 1'b0;
    b1 = 1'b0;
    cin1 = 1'b0;
    check("w1 busy", busy1, 1);
    lat = 1;
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("w1 latency", lat, 2);
    check("w1 sum", sum1, 1);
    check("w1 cout", cout1, 1);
    @(negedge clk);
    check("w1 done width", done1, 0);

    @(negedge clk);
    a1 = 1'b1;
    b1 = 1'b0;
    cin1 = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("w1b latency", lat, 2);
    check("w1b sum", sum1, 1);
    check("w1b cout", cout1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
